// File: rtl/regfile_dump_reader_if.sv
// Signal bundle between the register-file dump reader, its control, the
// register file read port and the byte stream toward the transmit path.
interface regfile_dump_reader_if #(
    parameter int D = 5,
    parameter int W = 32
);
    logic         start;
    logic [D-1:0] first_addr;
    logic [D-1:0] last_addr;
    logic [D-1:0] rf_addr;
    logic [W-1:0] rf_data;
    logic [7:0]   byte_out;
    logic         byte_valid;
    logic         byte_ready;
    logic         busy;
    logic         done;

    modport master (
        input  start, first_addr, last_addr, rf_data, byte_ready,
        output rf_addr, byte_out, byte_valid, busy, done
    );

    modport slave (
        output start, first_addr, last_addr, rf_data, byte_ready,
        input  rf_addr, byte_out, byte_valid, busy, done
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a register-file address range and streams each word out LSB byte first.
// Latency: first byte valid one cycle after start; one SETUP cycle between words.
// Backpressure: byte_out/byte_valid hold until byte_ready; no bubble inside a word.
module regfile_dump_reader #(
    parameter int D = 5,
    parameter int W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_dump_reader_if.master  bus
);
    localparam int NB = W / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SEND, FINISH} state_t;

    state_t        state, state_nxt;
    logic [D-1:0]  cur;
    logic [D-1:0]  last;
    logic [D-1:0]  rf_addr_q;
    logic [W-1:0]  shift;
    logic [CW-1:0] cnt;
    logic          hs;
    logic          word_end;

    assign hs             = bus.byte_valid && bus.byte_ready;
    assign word_end       = hs && (cnt == CNT_LAST);
    assign bus.byte_valid = (state == SEND);
    assign bus.byte_out   = shift[7:0];
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == FINISH);
    assign bus.rf_addr    = rf_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = SETUP;
            SETUP:   state_nxt = SEND;
            SEND:    if (word_end) state_nxt = (cur == last) ? FINISH : SETUP;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            last      <= '0;
            rf_addr_q <= '0;
            shift     <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cur       <= bus.first_addr;
                        last      <= bus.last_addr;
                        rf_addr_q <= bus.first_addr;
                    end
                end
                SETUP: begin
                    // rf_addr has been stable all cycle, so rf_data is settled here
                    shift <= bus.rf_data;
                    cnt   <= '0;
                end
                SEND: begin
                    if (hs) begin
                        shift <= shift >> 8;
                        cnt   <= cnt + 1'b1;
                        if (word_end && (cur != last)) begin
                            cur       <= cur + 1'b1;
                            rf_addr_q <= cur + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;
    localparam int D  = 5;
    localparam int W  = 32;
    localparam int NB = W / 8;
    localparam int NR = 2 ** D;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_dump_reader_if #(.D(D), .W(W)) bus ();
    regfile_dump_reader #(.D(D), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [W-1:0] rf [0:NR-1];
    assign bus.rf_data = rf[bus.rf_addr];

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;
    logic [7:0]  exp_q [$];
    int          done_cnt   = 0;
    int unsigned done_cyc   = 0;
    int          ready_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = repeating 0,0,1, 2 = random
    initial begin
        int ph;
        ph = 0;
        bus.byte_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.byte_ready = 1'b1;
                1: begin
                    ph = (ph + 1) % 3;
                    bus.byte_ready = (ph == 2);
                end
                default: bus.byte_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks hold and done rules
    initial begin
        bit         prev_hold;
        bit         prev_done;
        logic [7:0] prev_byte;
        prev_hold = 0;
        prev_done = 0;
        prev_byte = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 0;
                prev_done = 0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", bus.byte_valid, 1);
                    check("hold_byte", bus.byte_out, prev_byte);
                end
                if (prev_done) begin
                    check("busy_after_done", bus.busy, 0);
                    check("done_width", bus.done, 0);
                end
                if (bus.byte_valid && bus.byte_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_byte: got %0h expected none", bus.byte_out);
                    end else begin
                        check("byte", bus.byte_out, exp_q.pop_front());
                    end
                end
                prev_hold = bus.byte_valid && !bus.byte_ready;
                prev_byte = bus.byte_out;
                if (bus.done) begin
                    check("busy_in_done", bus.busy, 1);
                    check("bytes_left_at_done", exp_q.size(), 0);
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_done = bus.done;
            end
        end
    end

    task automatic push_expected(input logic [D-1:0] first, input logic [D-1:0] last, output int n);
        n = ((int'(last) - int'(first) + NR) % NR) + 1;
        for (int i = 0; i < n; i++) begin
            int addr;
            addr = (int'(first) + i) % NR;
            for (int b = 0; b < NB; b++) exp_q.push_back(8'(rf[addr] >> (8 * b)));
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < target) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, target);
        end
        #1;
    endtask

    task automatic run_dump(input logic [D-1:0] first, input logic [D-1:0] last,
                            input int mode, input bit check_lat, input bit poke);
        int          n;
        int          target;
        int unsigned c0;
        push_expected(first, last, n);
        ready_mode     = mode;
        target         = done_cnt + 1;
        bus.first_addr = first;
        bus.last_addr  = last;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        c0 = cyc;
        if (check_lat) begin
            @(negedge clk);
            check("valid_in_setup", bus.byte_valid, 0);
            check("rf_addr_first", bus.rf_addr, first);
            @(negedge clk);
            check("valid_latency", bus.byte_valid, 1);
        end
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            bus.start      = 1'b1;
            bus.first_addr = D'($urandom);
            bus.last_addr  = D'($urandom);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        wait_done(target, 3000);
        if (check_lat) check("done_cycle", done_cyc - c0, n * (NB + 1));
        if (poke) begin
            repeat (30) @(posedge clk);
            #1;
            check("single_done", done_cnt, target);
        end
    endtask

    initial begin
        int          n;
        int unsigned c0;
        bus.start      = 1'b0;
        bus.first_addr = '0;
        bus.last_addr  = '0;
        for (int i = 0; i < NR; i++) rf[i] = $urandom;
        rf[0] = '0;
        #2;
        check("rst_rf_addr", bus.rf_addr, 0);
        check("rst_byte_out", bus.byte_out, 0);
        check("rst_valid", bus.byte_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rf[3] = 32'hA1B2C3D4;
        run_dump(5'd3, 5'd3, 0, 1, 0);

        for (int k = 1; k <= 4; k++) rf[k] = 32'h11111111 * k;
        run_dump(5'd1, 5'd4, 0, 1, 0);

        run_dump(5'd30, 5'd1, 0, 1, 0);

        rf[5] = 32'hDEADBEEF;
        run_dump(5'd5, 5'd5, 1, 0, 0);

        // Reset during byte 2 of word 2 of an 8..10 dump
        push_expected(5'd8, 5'd10, n);
        ready_mode     = 0;
        bus.first_addr = 5'd8;
        bus.last_addr  = 5'd10;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        c0 = cyc;
        repeat (7) @(posedge clk);
        #3;
        check("pre_rst_busy", bus.busy, 1);
        check("pre_rst_rf_addr", bus.rf_addr, 9);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rf_addr", bus.rf_addr, 0);
        check("mid_rst_byte_out", bus.byte_out, 0);
        check("mid_rst_valid", bus.byte_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_busy", bus.busy, 0);
        run_dump(5'd12, 5'd14, 2, 0, 0);

        run_dump(5'd20, 5'd22, 0, 1, 1);

        for (int t = 0; t < 15; t++) begin
            int mode;
            for (int i = 1; i < NR; i++) rf[i] = $urandom;
            mode = $urandom_range(0, 2);
            run_dump(D'($urandom), D'($urandom), mode, mode == 0, t % 5 == 0);
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Sequential reader that walks a contiguous address range of the processor register file through one of its combinational read ports. It streams each register's contents out as bytes, LSB first, over a valid/ready handshake. It sits between the register file read port and the debug/UART transmit path. It is the consumer side of the register file: it reads back what the pipeline wrote.

Parameters:
D, 5, address width; register file holds 2^D registers.
W, 32, register word width in bits; must be a multiple of 8; NB = W/8 bytes per word.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a dump; sampled only in IDLE.
first_addr  input  D  first register address of the range; latched on accepted start.
last_addr  input  D  last register address of the range; latched on accepted start.
rf_addr  output  D  address driven to the register file read port.
rf_data  input  W  combinational read data returned for rf_addr.
byte_out  output  8  current byte of the word being sent.
byte_valid  output  1  byte_out holds a valid byte.
byte_ready  input  1  downstream accepts byte_out when high together with byte_valid.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the final byte of the range is accepted.

Behaviour:
- Reset (rst_n low, any time, including mid-dump): state forced to IDLE. rf_addr=0, byte_out=0, byte_valid=0, busy=0, done=0. Shift register, byte counter and latched range are cleared. No partial transfer resumes after reset.
- Clock and reset are the only timing inputs. Everything else is synchronous to posedge clk.
- States: IDLE, SETUP, SEND, FINISH.
- IDLE:
  - On start=1 at a posedge: latch first_addr into cur and last_addr into last, set rf_addr=first_addr, go to SETUP.
  - start=0: stay in IDLE; rf_addr holds its last value.
- SETUP:
  - rf_addr has been stable for the full cycle.
  - At the next posedge: load rf_data into the W-bit shift register, clear the byte counter, assert byte_valid, go to SEND.
  - Data written by the register file on the negedge inside this cycle is captured.
- SEND:
  - byte_out = shift[7:0].
  - byte_valid=1 and byte_out are held stable until byte_valid&byte_ready at a posedge.
  - On each handshake: shift right by 8 and increment the byte counter.
  - After handshake number NB:
    - if cur==last: deassert byte_valid, go to FINISH;
    - otherwise: cur=cur+1 modulo 2^D, rf_addr=cur+1, deassert byte_valid, go to SETUP.
  - No bubble is required between bytes of the same word. There is exactly one idle cycle (SETUP) between words.
- FINISH: done=1 for exactly this one cycle, busy=1, then go to IDLE. busy=0 from the following cycle.
- Range and wrap rules:
  - Word count = ((last-first) mod 2^D)+1.
  - last<first wraps through address 2^D-1 to 0.
  - first==last dumps exactly one register.
- Address 0 is dumped like any other address; its data is whatever the register file returns (zero).
- start while busy is ignored; it does not restart or queue.
- first_addr and last_addr changing while busy have no effect.
- Latency: start accepted at posedge 0 gives byte_valid high after posedge 1. A range of N words with byte_ready held high finishes with done high in cycle N*(NB+1)+1 after start acceptance.

Test Plan:
- Reset, then first=3, last=3, rf[3]=0xA1B2C3D4, byte_ready=1, start pulse -> byte_valid after 2 edges, bytes D4,C3,B2,A1 on consecutive cycles, done one cycle, busy low after.
- first=1, last=4, regs 1..4 = 0x11111111*k, byte_ready=1 -> 16 bytes in address order 1,2,3,4, one SETUP gap between words, done at cycle 21.
- Wrap: D=5, first=30, last=1 -> addresses 30,31,0,1 dumped; address 0 yields four 0x00 bytes; total 16 bytes.
- Backpressure: byte_ready toggled 0,0,1 pattern during dump of rf[5]=0xDEADBEEF -> each byte held stable while ready=0, sequence EF,BE,AD,DE intact, no duplicated or dropped bytes.
- Reset mid-dump: rst_n low during byte 2 of word 2 -> all outputs 0 immediately (asynchronously), IDLE. A fresh start then dumps the new range from the beginning.
- Start while busy: second start pulse and changed first_addr/last_addr during a dump -> ignored; exactly one done pulse; byte count matches the original range.
